// File: rtl/hamming_2d_stream_rx.sv
// Receive-side streaming front end for the interleaved 2-D Hamming link.
//
// Codeword layout (105 bits = 15 columns x 7 bits):
//   symbol k  == column k == codeword bits [7k+6:7k]
//   bit j of a column is position j+1 of a Hamming(7,4) column code:
//     parity at j=0,1,3; data rows 0..3 at j=2,4,5,6
//   row r (0..3) across columns 0..14 is a Hamming(15,11) row code,
//     column c is row position c+1: parity at c=0,1,3,7, data elsewhere
//   the 44 row-data bits form the interleaved word w[11*r+k] (k-th data column);
//   deinterleave: data[i] = w[(7*i) % 44]
//
// Decoding corrects any pattern with at most one error per column silently.
// If the column pass leaves residual errors (two errors in one column), the
// row pass still attempts a fix but the word is flagged uncorrectable.

// Column-then-row product decoder, purely combinational.
module hamming_2d_decoder (
  input  logic [104:0] cw_i,
  output logic [43:0]  data_o,
  output logic         err_o
);

  localparam int DCOL [11] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

  logic [6:0]       col;
  logic [2:0]       cs;
  logic [3:0][14:0] rows;
  logic [14:0]      row;
  logic [3:0]       rs;

  // Column syndromes fix one error per column, then row syndromes mop up residue.
  always_comb begin
    col    = '0;
    cs     = '0;
    rows   = '0;
    row    = '0;
    rs     = '0;
    data_o = '0;
    err_o  = 1'b0;
    for (int c = 0; c < 15; c++) begin
      col = cw_i[7*c +: 7];
      cs  = '0;
      for (int j = 0; j < 7; j++) begin
        if (col[j]) cs = cs ^ 3'(j + 1);
      end
      if (cs != 3'd0) col[cs - 3'd1] = ~col[cs - 3'd1];
      rows[0][c] = col[2];
      rows[1][c] = col[4];
      rows[2][c] = col[5];
      rows[3][c] = col[6];
    end
    for (int r = 0; r < 4; r++) begin
      row = rows[r];
      rs  = '0;
      for (int p = 0; p < 15; p++) begin
        if (row[p]) rs = rs ^ 4'(p + 1);
      end
      if (rs != 4'd0) begin
        err_o          = 1'b1;
        row[rs - 4'd1] = ~row[rs - 4'd1];
      end
      for (int k = 0; k < 11; k++) begin
        data_o[11*r + k] = row[DCOL[k]];
      end
    end
  end

endmodule

// Undo the stride-7 bit interleave applied by the transmitter.
module deinterleaver_44bit (
  input  logic [43:0] in_i,
  output logic [43:0] out_o
);

  // Output bit i comes from interleaved position (7*i) mod 44.
  always_comb begin
    out_o = '0;
    for (int i = 0; i < 44; i++) begin
      out_o[i] = in_i[(7*i) % 44];
    end
  end

endmodule

// Symbol assembly, framing check, decode hand-off and link statistics.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; a producer holds its data stable while valid=1 and ready=0.
module hamming_2d_stream_rx #(
  parameter int CNT_W  = 16,
  parameter int FERR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [43:0]       out_data,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cw_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [FERR_W-1:0] ferr_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FULL    = 2'd1,
    ST_RESYNC  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [104:0]        asm_q, asm_d;
  logic [3:0]          idx_q, idx_d;
  logic                in_ready_q, in_ready_d;
  logic [43:0]         out_data_q, out_data_d;
  logic                out_err_q, out_err_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    cw_cnt_q, cw_cnt_d;
  logic [CNT_W-1:0]    uncorr_cnt_q, uncorr_cnt_d;
  logic [FERR_W-1:0]   ferr_cnt_q, ferr_cnt_d;

  logic [43:0] dec_word;
  logic [43:0] dec_data;
  logic        dec_err;
  logic        in_hs;
  logic        cw_inc, uncorr_inc, ferr_inc;

  hamming_2d_decoder u_dec (
    .cw_i   (asm_q),
    .data_o (dec_word),
    .err_o  (dec_err)
  );

  deinterleaver_44bit u_deint (
    .in_i  (dec_word),
    .out_o (dec_data)
  );

  // Next-state for the assembly FSM, output register and counters.
  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    idx_d        = idx_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    cw_cnt_d     = cw_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    ferr_cnt_d   = ferr_cnt_q;
    cw_inc       = 1'b0;
    uncorr_inc   = 1'b0;
    ferr_inc     = 1'b0;
    in_hs        = in_valid & in_ready_q;

    // A drained word frees the register unless a load below refills it.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (in_hs) begin
          for (int k = 0; k < 15; k++) begin
            if (idx_q == 4'(k)) asm_d[7*k +: 7] = in_data;
          end
          if (in_last) begin
            if (idx_q == 4'd14) begin
              state_d = ST_FULL;
            end else begin
              idx_d    = 4'd0;
              ferr_inc = 1'b1;
            end
          end else if (idx_q == 4'd14) begin
            idx_d    = 4'd0;
            ferr_inc = 1'b1;
            state_d  = ST_RESYNC;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_FULL: begin
        if (!out_valid_q || out_ready) begin
          out_data_d  = dec_data;
          out_err_d   = dec_err;
          out_valid_d = 1'b1;
          cw_inc      = 1'b1;
          uncorr_inc  = dec_err;
          idx_d       = 4'd0;
          state_d     = ST_COLLECT;
        end
      end
      ST_RESYNC: begin
        if (in_hs && in_last) begin
          idx_d   = 4'd0;
          state_d = ST_COLLECT;
        end
      end
      default: begin
        idx_d   = 4'd0;
        state_d = ST_COLLECT;
      end
    endcase

    in_ready_d = (state_d != ST_FULL);

    // Clear beats any same-cycle increment; increments stop at all-ones.
    if (clr_cnt) begin
      cw_cnt_d     = '0;
      uncorr_cnt_d = '0;
      ferr_cnt_d   = '0;
    end else begin
      if (cw_inc && (cw_cnt_q != '1))         cw_cnt_d     = cw_cnt_q + CNT_W'(1);
      if (uncorr_inc && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      if (ferr_inc && (ferr_cnt_q != '1))     ferr_cnt_d   = ferr_cnt_q + FERR_W'(1);
    end
  end

  // Register all state; reset drops any partial codeword and pending output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      asm_q        <= '0;
      idx_q        <= 4'd0;
      in_ready_q   <= 1'b1;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      cw_cnt_q     <= '0;
      uncorr_cnt_q <= '0;
      ferr_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      idx_q        <= idx_d;
      in_ready_q   <= in_ready_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      cw_cnt_q     <= cw_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      ferr_cnt_q   <= ferr_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign out_valid  = out_valid_q;
  assign cw_cnt     = cw_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
  assign ferr_cnt   = ferr_cnt_q;
  assign dbg_state  = state_q;

endmodule
